// File: rtl/ara_cluster_resp_join_pkg.sv
// ---------------------------------------------------------------------------
// ara_pkg
// Shared types for the Ara cluster response join.
//   resp_join_entry_t : one order-FIFO entry {trans_id, wb}
//   cluster_resp_t    : one per-cluster collect slot payload {result, error}
// The struct field widths follow the package constants below. The join's
// DataWidth / TransIdWidth parameters default to these constants and must
// match them.
// ---------------------------------------------------------------------------
package ara_pkg;

  localparam int unsigned RespJoinDataWidth    = 64;
  localparam int unsigned RespJoinTransIdWidth = 3;

  typedef struct packed {
    logic [RespJoinTransIdWidth-1:0] trans_id;
    logic                            wb;
  } resp_join_entry_t;

  typedef struct packed {
    logic [RespJoinDataWidth-1:0] result;
    logic                         error;
  } cluster_resp_t;

endpackage

// File: rtl/ara_cluster_resp_join_fifo.sv
// ---------------------------------------------------------------------------
// fifo_v3
// Small synchronous FIFO with the common_cells fifo_v3 interface.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : drop all entries
//   testmode_i     : unused here, kept for interface compatibility
//   full_o/empty_o : status flags
//   usage_o        : fill level modulo DEPTH (full_o disambiguates DEPTH)
//   data_i/push_i  : write side (push ignored while full)
//   data_o/pop_i   : read side, data_o shows the head entry
// Storage is reset to zero so the head reads as zero out of reset.
// ---------------------------------------------------------------------------
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

  logic [ADDR_DEPTH-1:0] read_ptr_reg, write_ptr_reg;
  logic [ADDR_DEPTH:0]   status_cnt_reg;
  dtype                  mem_reg [FifoDepth];
  logic                  push_eff, pop_eff, bypass;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  assign full_o  = (status_cnt_reg == (ADDR_DEPTH+1)'(FifoDepth));
  // In fall-through mode a push into an empty FIFO is visible immediately.
  assign bypass  = FALL_THROUGH && (status_cnt_reg == '0) && push_i;
  assign empty_o = (status_cnt_reg == '0) && !bypass;
  assign usage_o = status_cnt_reg[ADDR_DEPTH-1:0];
  assign data_o  = bypass ? data_i : mem_reg[read_ptr_reg];

  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_ptr_reg   <= '0;
      write_ptr_reg  <= '0;
      status_cnt_reg <= '0;
      for (int i = 0; i < FifoDepth; i++) mem_reg[i] <= '0;
    end else if (flush_i) begin
      read_ptr_reg   <= '0;
      write_ptr_reg  <= '0;
      status_cnt_reg <= '0;
    end else if (bypass && pop_i) begin
      // Entry passes straight through; nothing is stored.
      status_cnt_reg <= status_cnt_reg;
    end else begin
      if (push_eff) begin
        mem_reg[write_ptr_reg] <= data_i;
        write_ptr_reg <= (write_ptr_reg == ADDR_DEPTH'(FifoDepth-1)) ? '0 : write_ptr_reg + 1'b1;
      end
      if (pop_eff) begin
        read_ptr_reg <= (read_ptr_reg == ADDR_DEPTH'(FifoDepth-1)) ? '0 : read_ptr_reg + 1'b1;
      end
      if (push_eff && !pop_eff)      status_cnt_reg <= status_cnt_reg + 1'b1;
      else if (!push_eff && pop_eff) status_cnt_reg <= status_cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/ara_cluster_resp_join.sv
// ---------------------------------------------------------------------------
// ara_cluster_resp_join
// Joins per-cluster Ara responses into one in-order response for CVA6.
// Issued requests are recorded in an order FIFO; each cluster fills its own
// collect slot, and the merged response is released once all slots are full.
//   issue_*        : request entering the fork (issue_ready_o = credit left)
//   cluster_resp_* : per-cluster response handshake, result and error
//   resp_*         : merged response toward CVA6
//   mismatch_o     : sticky cluster-result disagreement flag
// Optional feature macro: ARA_RESP_JOIN_CHECK_EN enables the result
// comparator, the sticky mismatch_o flag and a simulation assertion. When
// undefined mismatch_o is tied low.
// ---------------------------------------------------------------------------
module ara_cluster_resp_join
  import ara_pkg::*;
#(
  parameter int unsigned NrClusters     = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned DataWidth      = RespJoinDataWidth,
  parameter int unsigned TransIdWidth   = RespJoinTransIdWidth
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [TransIdWidth-1:0]         issue_trans_id_i,
  input  logic                            issue_wb_i,
  input  logic [NrClusters-1:0]           cluster_resp_valid_i,
  output logic [NrClusters-1:0]           cluster_resp_ready_o,
  input  logic [NrClusters*DataWidth-1:0] cluster_resp_result_i,
  input  logic [NrClusters-1:0]           cluster_resp_error_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [TransIdWidth-1:0]         resp_trans_id_o,
  output logic [DataWidth-1:0]            resp_result_o,
  output logic                            resp_error_o,
  output logic                            mismatch_o
);

  localparam int unsigned AddrWidth = $clog2(MaxOutstanding);

  resp_join_entry_t       issue_entry, head_entry;
  logic                   fifo_full, fifo_empty;
  logic [AddrWidth-1:0]   fifo_usage;
  logic [AddrWidth:0]     occupancy;
  logic                   issue_push, retire;

  cluster_resp_t          slot_reg [NrClusters];
  logic [NrClusters-1:0]  collected_reg;
  logic [NrClusters-1:0]  cluster_hs;
  logic [NrClusters-1:0]  slot_error;

  // -------------------------------------------------------------------------
  // Order FIFO
  // -------------------------------------------------------------------------
  assign issue_entry.trans_id = issue_trans_id_i;
  assign issue_entry.wb       = issue_wb_i;

  // usage_o wraps to 0 when full, so full_o supplies the top count.
  assign occupancy     = fifo_full ? (AddrWidth+1)'(MaxOutstanding) : {1'b0, fifo_usage};
  assign issue_ready_o = (occupancy != (AddrWidth+1)'(MaxOutstanding));
  assign issue_push    = issue_valid_i && issue_ready_o;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (MaxOutstanding),
    .dtype        (resp_join_entry_t)
  ) i_order_fifo (
    .clk_i      (clk_i),
    .rst_ni     (~rst_i),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (fifo_usage),
    .data_i     (issue_entry),
    .push_i     (issue_push),
    .data_o     (head_entry),
    .pop_i      (retire)
  );

  // -------------------------------------------------------------------------
  // Collect slots
  // -------------------------------------------------------------------------
  // Ready uses the pre-clear collected bits, so no cluster is accepted in the
  // retire cycle (all bits are set then).
  for (genvar gi = 0; gi < NrClusters; gi++) begin : g_slot
    assign cluster_resp_ready_o[gi] = !fifo_empty && !collected_reg[gi];
    assign cluster_hs[gi]           = cluster_resp_valid_i[gi] && cluster_resp_ready_o[gi];
    assign slot_error[gi]           = slot_reg[gi].error;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      collected_reg <= '0;
      for (int i = 0; i < NrClusters; i++) slot_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NrClusters; i++) begin
        if (retire) begin
          collected_reg[i] <= 1'b0;
          slot_reg[i]      <= '0;
        end else if (cluster_hs[i]) begin
          collected_reg[i]    <= 1'b1;
          slot_reg[i].result  <= cluster_resp_result_i[i*DataWidth +: DataWidth];
          slot_reg[i].error   <= cluster_resp_error_i[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Merge
  // -------------------------------------------------------------------------
  assign resp_valid_o    = &collected_reg;
  assign retire          = resp_valid_o && resp_ready_i;
  assign resp_trans_id_o = head_entry.trans_id;
  assign resp_result_o   = head_entry.wb ? slot_reg[0].result : '0;
  assign resp_error_o    = |slot_error;

  // -------------------------------------------------------------------------
  // Optional result checker
  // -------------------------------------------------------------------------
`ifdef ARA_RESP_JOIN_CHECK_EN
  logic result_diff;
  logic mismatch_reg;

  always_comb begin
    result_diff = 1'b0;
    for (int i = 1; i < NrClusters; i++) begin
      if (slot_reg[i].result != slot_reg[0].result) result_diff = 1'b1;
    end
  end

  // Only scalar-writeback requests carry a meaningful result to compare.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_reg <= 1'b0;
    end else if (resp_valid_o && head_entry.wb && result_diff) begin
      mismatch_reg <= 1'b1;
    end
  end

  assign mismatch_o = mismatch_reg;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && resp_valid_o && head_entry.wb) begin
      assert (!result_diff)
        else $error("ara_cluster_resp_join: cluster results disagree for trans_id %0d",
                    head_entry.trans_id);
    end
  end
`endif
`else
  assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_ara_cluster_resp_join.sv
module tb_ara_cluster_resp_join;

  localparam int NC = 2;
  localparam int DW = 64;
  localparam int TW = 3;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [TW-1:0]   issue_trans_id_i;
  logic            issue_wb_i;
  logic [NC-1:0]   cluster_resp_valid_i;
  logic [NC-1:0]   cluster_resp_ready_o;
  logic [NC*DW-1:0] cluster_resp_result_i;
  logic [NC-1:0]   cluster_resp_error_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [TW-1:0]   resp_trans_id_o;
  logic [DW-1:0]   resp_result_o;
  logic            resp_error_o;
  logic            mismatch_o;

  int errors = 0;
  int checks = 0;
  logic exp_mm;
  logic [TW-1:0] drain_ids [4];

  always #5 clk = ~clk;

  ara_cluster_resp_join #(
    .NrClusters(NC), .MaxOutstanding(4), .DataWidth(DW), .TransIdWidth(TW)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .issue_valid_i         (issue_valid_i),
    .issue_ready_o         (issue_ready_o),
    .issue_trans_id_i      (issue_trans_id_i),
    .issue_wb_i            (issue_wb_i),
    .cluster_resp_valid_i  (cluster_resp_valid_i),
    .cluster_resp_ready_o  (cluster_resp_ready_o),
    .cluster_resp_result_i (cluster_resp_result_i),
    .cluster_resp_error_i  (cluster_resp_error_i),
    .resp_valid_o          (resp_valid_o),
    .resp_ready_i          (resp_ready_i),
    .resp_trans_id_o       (resp_trans_id_o),
    .resp_result_o         (resp_result_o),
    .resp_error_o          (resp_error_o),
    .mismatch_o            (mismatch_o)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) begin
      $display("check %s: observed=%0h expected=%0h ok", tag, observed, expected);
    end else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clusters(input logic [NC-1:0] v, input logic [63:0] r0, input logic [63:0] r1,
                          input logic [NC-1:0] e);
    cluster_resp_valid_i  = v;
    cluster_resp_result_i = {r1, r0};
    cluster_resp_error_i  = e;
  endtask

  task automatic retire_one();
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
  endtask

  initial begin
`ifdef ARA_RESP_JOIN_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    drain_ids[0] = 3'd1; drain_ids[1] = 3'd2; drain_ids[2] = 3'd3; drain_ids[3] = 3'd5;

    rst_i = 1'b1;
    issue_valid_i = 1'b0; issue_trans_id_i = '0; issue_wb_i = 1'b0;
    resp_ready_i = 1'b0;
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    step(); step();

    // Reset state
    check("rst_issue_ready", issue_ready_o, 1);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_cluster_ready", cluster_resp_ready_o, 0);
    check("rst_mismatch", mismatch_o, 0);
    check("rst_trans_id", resp_trans_id_o, 0);
    check("rst_result", resp_result_o, 0);
    check("rst_error", resp_error_o, 0);
    rst_i = 1'b0;

    // Single request ID=3 wb=1, staggered cluster answers
    issue_valid_i = 1'b1; issue_trans_id_i = 3'd3; issue_wb_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    check("t1_cluster_ready_both", cluster_resp_ready_o, 2'b11);
    check("t1_valid_before", resp_valid_o, 0);
    clusters(2'b01, 64'hDEAD, 64'h0, 2'b00);
    step();
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    check("t1_cluster_ready_c1", cluster_resp_ready_o, 2'b10);
    check("t1_valid_partial", resp_valid_o, 0);
    clusters(2'b10, 64'h0, 64'hDEAD, 2'b00);
    step();
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    check("t1_valid", resp_valid_o, 1);
    check("t1_trans_id", resp_trans_id_o, 3);
    check("t1_result", resp_result_o, 64'hDEAD);
    check("t1_error", resp_error_o, 0);
    retire_one();
    check("t1_valid_after", resp_valid_o, 0);
    check("t1_ready_empty", cluster_resp_ready_o, 0);

    // Fill four outstanding, fifth held off, retire-on-full refuses issue
    for (int k = 0; k < 4; k++) begin
      issue_valid_i = 1'b1; issue_trans_id_i = TW'(k); issue_wb_i = 1'b0;
      step();
    end
    issue_trans_id_i = 3'd5;
    check("t2_full_ready", issue_ready_o, 0);
    clusters(2'b11, 64'h7, 64'h8, 2'b00);
    step();
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    check("t2_full_held", issue_ready_o, 0);
    check("t2_head_valid", resp_valid_o, 1);
    check("t2_head_id", resp_trans_id_o, 0);
    check("t2_wb0_result", resp_result_o, 0);
    retire_one();
    check("t2_ready_after_retire", issue_ready_o, 1);
    step();
    issue_valid_i = 1'b0;
    check("t2_refull", issue_ready_o, 0);
    for (int k = 0; k < 4; k++) begin
      clusters(2'b11, 64'h1, 64'h1, 2'b00);
      step();
      clusters(2'b00, 64'h0, 64'h0, 2'b00);
      check("t2_drain_valid", resp_valid_o, 1);
      check("t2_drain_id", resp_trans_id_o, 64'(drain_ids[k]));
      retire_one();
    end
    check("t2_empty_ready", issue_ready_o, 1);
    check("t2_empty_cluster_ready", cluster_resp_ready_o, 0);

    // Cluster responses while nothing pending are stalled, not dropped
    clusters(2'b11, 64'h55, 64'h55, 2'b00);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_stall_ready", cluster_resp_ready_o, 0);
      check("t3_stall_valid", resp_valid_o, 0);
    end
    issue_valid_i = 1'b1; issue_trans_id_i = 3'd6; issue_wb_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    check("t3_ready_now", cluster_resp_ready_o, 2'b11);
    step();
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    check("t3_valid", resp_valid_o, 1);
    check("t3_id", resp_trans_id_o, 6);
    check("t3_result", resp_result_o, 64'h55);
    retire_one();

    // IDs 1 and 2 with backpressure on the merged response
    issue_valid_i = 1'b1; issue_trans_id_i = 3'd1; issue_wb_i = 1'b1;
    step();
    issue_trans_id_i = 3'd2;
    step();
    issue_valid_i = 1'b0;
    clusters(2'b11, 64'h11, 64'h11, 2'b00);
    step();
    clusters(2'b11, 64'h22, 64'h22, 2'b00);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", resp_valid_o, 1);
      check("t4_hold_id", resp_trans_id_o, 1);
      check("t4_hold_result", resp_result_o, 64'h11);
      check("t4_hold_cl_ready", cluster_resp_ready_o, 0);
      step();
    end
    retire_one();
    check("t4_after_retire_valid", resp_valid_o, 0);
    check("t4_after_retire_cl_ready", cluster_resp_ready_o, 2'b11);
    step();
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    check("t4_second_valid", resp_valid_o, 1);
    check("t4_second_id", resp_trans_id_o, 2);
    check("t4_second_result", resp_result_o, 64'h22);
    retire_one();
    check("t4_drained", cluster_resp_ready_o, 0);

    // Error merge with wb=0
    issue_valid_i = 1'b1; issue_trans_id_i = 3'd4; issue_wb_i = 1'b0;
    step();
    issue_valid_i = 1'b0;
    clusters(2'b11, 64'h99, 64'h99, 2'b10);
    step();
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    check("t5_valid", resp_valid_o, 1);
    check("t5_error", resp_error_o, 1);
    check("t5_result", resp_result_o, 0);
    check("t5_id", resp_trans_id_o, 4);
    retire_one();

    // Result disagreement on wb=1
    issue_valid_i = 1'b1; issue_trans_id_i = 3'd7; issue_wb_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    clusters(2'b11, 64'h1, 64'h2, 2'b00);
    step();
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    check("t6_valid", resp_valid_o, 1);
    check("t6_result", resp_result_o, 64'h1);
    retire_one();
    check("t6_mismatch", mismatch_o, 64'(exp_mm));
    step();
    check("t6_mismatch_sticky", mismatch_o, 64'(exp_mm));

    // Asynchronous reset mid-transaction
    issue_valid_i = 1'b1; issue_trans_id_i = 3'd2; issue_wb_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    clusters(2'b01, 64'h5, 64'h0, 2'b01);
    step();
    clusters(2'b00, 64'h0, 64'h0, 2'b00);
    check("t7_pre_id", resp_trans_id_o, 2);
    check("t7_pre_cl_ready", cluster_resp_ready_o, 2'b10);
    #2;
    rst_i = 1'b1;
    #1;
    check("t7_rst_issue_ready", issue_ready_o, 1);
    check("t7_rst_cl_ready", cluster_resp_ready_o, 0);
    check("t7_rst_valid", resp_valid_o, 0);
    check("t7_rst_mismatch", mismatch_o, 0);
    check("t7_rst_id", resp_trans_id_o, 0);
    check("t7_rst_result", resp_result_o, 0);
    check("t7_rst_error", resp_error_o, 0);
    step();
    rst_i = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ara_cluster_resp_join.md
# ara_cluster_resp_join

Sequences accelerator responses coming back from the Ara clusters fed by the request fork toward CVA6. Every request issued to the fork is tracked in an order FIFO. Each cluster's response is collected, and one merged response per request is released to CVA6 once all clusters have answered. The outstanding-request credit also throttles how fast new requests may enter the fork.

## Interface
- NrClusters, 2, number of clusters behind the fork (≥1)
- MaxOutstanding, 4, maximum issued-but-unretired requests; power of two, ≥2
- DataWidth, 64, result width
- TransIdWidth, 3, transaction ID width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- issue_valid_i  in  1  request is entering the fork this cycle
- issue_ready_o  out  1  credit available; request may be accepted
- issue_trans_id_i  in  TransIdWidth  ID of the issued request
- issue_wb_i  in  1  request expects a scalar result
- cluster_resp_valid_i  in  NrClusters  per-cluster response valid
- cluster_resp_ready_o  out  NrClusters  per-cluster response accepted
- cluster_resp_result_i  in  NrClusters×DataWidth  per-cluster result
- cluster_resp_error_i  in  NrClusters  per-cluster exception flag
- resp_valid_o  out  1  merged response valid to CVA6
- resp_ready_i  in  1  CVA6 accepts merged response
- resp_trans_id_o  out  TransIdWidth  ID at head of order FIFO
- resp_result_o  out  DataWidth  merged result
- resp_error_o  out  1  merged exception flag
- mismatch_o  out  1  sticky result-mismatch flag (macro-dependent)

## Operation
- Order FIFO, depth MaxOutstanding. Each entry holds {trans_id, wb}. An issue handshake (issue_valid_i && issue_ready_o) pushes one entry.
- issue_ready_o = FIFO not full. It depends only on registered state; there is no combinational path from resp_ready_i.
- Per-cluster collect slot, one per cluster. Each slot holds a collected bit, the result, and the error flag.
- cluster_resp_ready_o[i] = FIFO not empty && !collected[i]. A cluster's handshake sets collected[i] and captures its result and error.
- Responses arriving while the FIFO is empty are stalled (ready low). They are never dropped.
- resp_valid_o = &collected. This requires the FIFO to be non-empty, which the ready rule already guarantees.
- Merged fields:
  - resp_trans_id_o = head trans_id.
  - resp_result_o = cluster 0 result when head wb=1, else 0.
  - resp_error_o = OR of all captured error flags.
- Retire on resp_valid_o && resp_ready_i: pop the FIFO and clear all collected bits in the same cycle.
- A new cluster handshake in the retire cycle is not accepted, because ready is computed from the pre-clear collected bits.
- Simultaneous issue and retire on a full FIFO: the issue is refused. The slot frees on the next cycle.
- Simultaneous issue and retire on a non-full FIFO: both occur and the occupancy is unchanged.
- The occupancy counter is $clog2(MaxOutstanding)+1 bits wide. Read and write pointers wrap modulo MaxOutstanding.
- Reset mid-operation discards all FIFO entries and collected bits. Any in-flight responses are lost by design.

## Timing
- Reset values:
  - issue_ready_o=1, resp_valid_o=0, cluster_resp_ready_o=0, mismatch_o=0.
  - resp_trans_id_o, resp_result_o and resp_error_o are 0.
- Latency from the last cluster handshake to resp_valid_o is 1 cycle, because the collected bits are registered.
- Minimum issue-to-response latency is 2 cycles. The issue in cycle 0 makes the FIFO non-empty in cycle 1, the cluster handshake occurs in cycle 1, and resp_valid_o rises in cycle 2.
- Sustained throughput is one merged response every 2 cycles. The collect cycle and retire cycle alternate.
- Once resp_valid_o rises, it and all merged fields stay stable until resp_ready_i is sampled high.

## Configuration
- ARA_RESP_JOIN_CHECK_EN defined:
  - At capture, compare every cluster result against cluster 0.
  - For a wb=1 head, any difference sets mismatch_o. mismatch_o is sticky and cleared only by reset.
  - A simulation assertion also fires on any mismatch.
- ARA_RESP_JOIN_CHECK_EN undefined: no comparators are built, mismatch_o is tied to 0, and there is no assertion.

## Structure
- Typedefs belong in ara_pkg:
  - resp_join_entry_t, holding {trans_id, wb}.
  - cluster_resp_t, holding {result, error}.
- The order FIFO reuses fifo_v3 from common_cells, configured with DEPTH=MaxOutstanding and FALL_THROUGH=0. Occupancy is taken from usage_o plus full_o.
- No other sub-module. The collect slots, merge logic and checker are local logic.

## Test plan
- Single request, ID=3, wb=1, NrClusters=2. Cluster 0 returns 0xDEAD and cluster 1 returns 0xDEAD one cycle later. Expect resp_valid_o one cycle after the cluster 1 handshake, with trans_id=3 and result=0xDEAD.
- Issue 4 requests back-to-back with no cluster responses. Expect issue_ready_o=0 after the fourth issue and a fifth issue_valid_i to be held off. After one retire, expect issue_ready_o=1 on the next cycle.
- Cluster response valid while no request is pending. Expect cluster_resp_ready_o=0 and resp_valid_o=0 throughout.
- Request IDs 1 and 2 with resp_ready_i held low for 5 cycles. Expect resp_valid_o to hold and the ID 2 collection to wait. On release, expect responses in order 1 then 2, with no loss.
- Cluster 1 error=1 and cluster 0 error=0, wb=0. Expect resp_error_o=1 and resp_result_o=0.
- With ARA_RESP_JOIN_CHECK_EN and wb=1, results 0x1 and 0x2 give mismatch_o=1, which persists until reset. Asserting rst_i mid-transaction clears all outputs to their reset values asynchronously.
